serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Uses a single 1-bit full-subtractor cell and a registered borrow.
- It is the inverse-direction counterpart of the team's full adder datapath.
- Sits beside the adder blocks as a low-area arithmetic unit with a start/busy/done handshake for a sequencing controller.

Parameters:
- WIDTH, 8, operand and result width in bits (must be at least 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while SHIFT is active.
- done  output  1  one-cycle pulse when the result becomes valid.
- diff  output  WIDTH  registered difference; held until the next result.
- bout  output  1  registered borrow-out; held with diff.

Behaviour:
- Reset:
  - Asynchronous and active-high; the clock and reset are fixed as stated.
  - state=IDLE; busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow flop and bit counter cleared.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1, capture a into sa, b into sb, and bin into the borrow flop br; clear cnt; go to SHIFT. Otherwise stay.
  - SHIFT:
    - Each cycle computes d = sa[0]^sb[0]^br and nb = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
    - sa and sb shift right by one.
    - The result shift register sr shifts right with d entering at bit WIDTH-1.
    - br <= nb; cnt <= cnt+1.
    - When cnt==WIDTH-1 the shift completes, then go to DONE.
  - DONE: load diff <= sr (the final shifted value, including the last bit) and bout <= br; done=1 for this cycle only; go to IDLE unconditionally.
- Output timing:
  - busy is high exactly when state==SHIFT, for WIDTH cycles.
  - done is registered and high exactly one cycle.
  - diff and bout are visible in the same cycle as done and in all later cycles.
  - Latency: start sampled at edge k; done high in the cycle following edge k+WIDTH+1.
  - Back-to-back minimum issue interval is WIDTH+2 cycles.
- diff and bout change only on the DONE transition or on reset. They are never updated while SHIFT is in progress.
- Arithmetic:
  - Modulo 2^WIDTH.
  - bout=1 iff a < b + bin as unsigned integers.
  - The counter is sized $clog2(WIDTH)+1 bits so it cannot wrap before the terminal count.
- Boundary conditions:
  - start while in SHIFT or DONE is ignored. No queuing; operands are not recaptured.
  - start held high continuously re-triggers on each return to IDLE.
  - Changes on a, b or bin after capture have no effect on the operation in flight.
  - Reset asserted mid-operation aborts immediately to IDLE with all outputs zero, and no done pulse is issued.
  - a==b with bin=0 gives diff=0, bout=0.
  - a=0 with b=0 and bin=1 gives diff=all ones, bout=1.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - the default width constant DEF_WIDTH=8.
- One natural sub-module, full_subtractor_bit:
  - purely combinational;
  - inputs x, y, bi; outputs d, bo;
  - instantiated once in the SHIFT datapath.

Test Plan:
- WIDTH=8, a=8'h05, b=8'h03, bin=0, one-cycle start -> busy high 8 cycles; done pulse at cycle 10 after start; diff=8'h02, bout=0.
- a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1; the previous diff (8'h02) stays stable on the outputs until this done.
- a=8'h10, b=8'h0F, bin=1 -> diff=8'h00, bout=0. Then a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1.
- Start accepted with a=8'h20, b=8'h01; start pulsed again at cycle 3 with a=8'h00 -> second start ignored; single done; diff=8'h1F.
- Start with a=8'h80, b=8'h01; rst asserted asynchronously at cycle 4 (mid-clock) -> outputs 0 immediately; no done; a new start after reset release gives diff=8'h7F, bout=0.
- Randomised sweep of 200 operand triples against a behavioural reference a-b-bin, together with an exhaustive WIDTH=2 run (32 cases) -> all diff and bout values match, and every done is exactly one cycle wide.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM encoding and default width.
package arith_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: d = x - y - bi, with borrow-out bo.
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, with a start/busy/done handshake.
// diff/bout are only written when a result completes, so they hold between operations.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             d_s;
    logic             nb_s;

    full_subtractor_bit u_fsb (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .bi (br_q),
        .d  (d_s),
        .bo (nb_s)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                sr_d  = {d_s, sr_q[WIDTH-1:1]};
                br_d  = nb_s;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                diff_d  = sr_q;
                bout_d  = br_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            done_q  <= done_d;
            busy_q  <= (state_d == ST_SHIFT);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed cases, reset abort, random sweep at
// WIDTH=8, and an exhaustive sweep on a second WIDTH=2 instance.
module tb_serial_subtractor;

    localparam int W  = 8;
    localparam int W2 = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          bin = 1'b0;
    logic          busy, done, bout;
    logic [W-1:0]  diff;

    logic          start2 = 1'b0;
    logic [W2-1:0] a2 = '0;
    logic [W2-1:0] b2 = '0;
    logic          bin2 = 1'b0;
    logic          busy2, done2, bout2;
    logic [W2-1:0] diff2;

    int checks = 0;
    int failures = 0;
    logic [W:0]    sb8_q[$];
    logic [W2:0]   sb2_q[$];
    logic [W-1:0]  prev_diff = '0;
    logic          prev_bout = 1'b0;
    int            abort_done;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(W2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; inject re-pulses start mid-SHIFT with a different operand.
    task automatic op8(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input bit inject);
        logic [W:0] exp;
        int busy_n, done_n, done_at, hold_bad;
        @(negedge clk);
        a = av; b = bv; bin = bi; start = 1'b1;
        sb8_q.push_back({1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi});
        busy_n = 0; done_n = 0; done_at = 0; hold_bad = 0;
        for (int j = 1; j <= W + 2; j++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = j; end
            if (j <= W + 1 && (diff !== prev_diff || bout !== prev_bout)) hold_bad++;
            if (j == 1) begin start = 1'b0; a = ~av; b = ~bv; bin = ~bi; end
            if (inject && j == 3) begin start = 1'b1; a = 8'h00; end
            if (inject && j == 4) start = 1'b0;
        end
        chk("busy_cycles", busy_n, W);
        chk("done_pulses", done_n, 1);
        chk("done_cycle", done_at, W + 2);
        chk("result_hold", hold_bad, 0);
        exp = sb8_q.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, exp[W-1:0]});
        chk("bout", {31'd0, bout}, {31'd0, exp[W]});
        prev_diff = exp[W-1:0];
        prev_bout = exp[W];
    endtask

    // One WIDTH=2 operation.
    task automatic op2(input logic [W2-1:0] av, input logic [W2-1:0] bv, input logic bi);
        logic [W2:0] exp;
        int busy_n, done_n, done_at;
        @(negedge clk);
        a2 = av; b2 = bv; bin2 = bi; start2 = 1'b1;
        sb2_q.push_back({1'b0, av} - {1'b0, bv} - {{W2{1'b0}}, bi});
        busy_n = 0; done_n = 0; done_at = 0;
        for (int j = 1; j <= W2 + 2; j++) begin
            @(negedge clk);
            if (busy2) busy_n++;
            if (done2) begin done_n++; done_at = j; end
            if (j == 1) start2 = 1'b0;
        end
        chk("w2_busy_cycles", busy_n, W2);
        chk("w2_done_pulses", done_n, 1);
        chk("w2_done_cycle", done_at, W2 + 2);
        exp = sb2_q.pop_front();
        chk("w2_diff", {30'd0, diff2}, {30'd0, exp[W2-1:0]});
        chk("w2_bout", {31'd0, bout2}, {31'd0, exp[W2]});
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_bout", {31'd0, bout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        op8(8'h05, 8'h03, 1'b0, 1'b0);
        op8(8'h00, 8'h01, 1'b0, 1'b0);
        op8(8'h10, 8'h0F, 1'b1, 1'b0);
        op8(8'hFF, 8'hFF, 1'b1, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 1'b0);
        op8(8'h5A, 8'h5A, 1'b0, 1'b0);
        op8(8'h20, 8'h01, 1'b0, 1'b1);

        // Reset mid-operation: outputs clear at once and no done follows.
        @(negedge clk);
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_bout", {31'd0, bout}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        abort_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) abort_done++;
        end
        chk("abort_quiet", abort_done, 0);
        prev_diff = '0;
        prev_bout = 1'b0;
        op8(8'h80, 8'h01, 1'b0, 1'b0);

        for (int k = 0; k < 200; k++) begin
            op8(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
        @(negedge clk);
        chk("done_fall", {31'd0, done}, 32'd0);

        for (int i = 0; i < 32; i++) begin
            op2(i[4:3], i[2:1], i[0]);
        end
        @(negedge clk);
        chk("w2_done_fall", {31'd0, done2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
